// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the bus register block.
// First-word-fall-through: the head entry is always driven on rd_data (zero while empty).
// Status outputs: empty, full, count and a sticky overflow flag.
module uart_rx_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_strobe,
    input  logic                  rd_strobe,
    input  logic                  clr_overflow,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int unsigned          Depth    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  MaxCount = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0]  OneCount = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] OnePtr  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  push_ok, pop_ok, push_drop;

    // Status and head data straight from registered state.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == MaxCount);
        count    = count_q;
        overflow = overflow_q;
        rd_data  = empty ? '0 : mem[rd_ptr_q];
    end

    // Accept/drop decisions and next-state for pointers, count and overflow.
    always_comb begin
        // A pop frees the slot the push needs, so push+pop on full is legal.
        push_ok   = wr_strobe & (~full | rd_strobe);
        pop_ok    = rd_strobe & ~empty;
        push_drop = wr_strobe & ~push_ok;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + OnePtr;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + OnePtr;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + OneCount;
            2'b01:   count_d = count_q - OneCount;
            default: count_d = count_q;
        endcase

        // Set wins over clear in the same cycle.
        if (push_drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are left alone by reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue holds the bytes the FIFO should contain,
// pushed when a write is driven and compared against rd_data when a pop is driven.
module tb_uart_rx_fifo;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned DEPTH      = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [WIDTH-1:0]    wr_data;
    logic                wr_strobe;
    logic                rd_strobe;
    logic                clr_overflow;
    logic [WIDTH-1:0]    rd_data;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;

    logic [WIDTH-1:0] sb_q [$];
    logic             ovf_m;
    logic [WIDTH-1:0] last_pop;
    int               n_checks = 0;
    int               n_pass   = 0;

    uart_rx_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_strobe    (wr_strobe),
        .rd_strobe    (rd_strobe),
        .clr_overflow (clr_overflow),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare all status outputs with the model.
    task automatic check_status(input string tag);
        logic [WIDTH-1:0] head;
        head = (sb_q.size() == 0) ? '0 : sb_q[0];
        check({tag, ".count"},    32'(count),    32'(sb_q.size()));
        check({tag, ".empty"},    32'(empty),    32'(sb_q.size() == 0));
        check({tag, ".full"},     32'(full),     32'(sb_q.size() == DEPTH));
        check({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
        check({tag, ".rd_data"},  32'(rd_data),  32'(head));
    endtask

    // One clock with the given strobes; inputs change 1 time unit after the edge.
    task automatic step(input logic push, input logic [WIDTH-1:0] d, input logic pop,
                        input logic clr, input string tag);
        logic push_ok, pop_ok;
        push_ok = push && ((sb_q.size() < DEPTH) || pop);
        pop_ok  = pop && (sb_q.size() != 0);
        if (pop_ok) begin
            check({tag, ".pop_data"}, 32'(rd_data), 32'(sb_q[0]));
        end
        wr_strobe    = push;
        wr_data      = d;
        rd_strobe    = pop;
        clr_overflow = clr;
        @(posedge clk);
        #1;
        wr_strobe    = 1'b0;
        rd_strobe    = 1'b0;
        clr_overflow = 1'b0;
        wr_data      = '0;
        if (pop_ok) last_pop = sb_q.pop_front();
        if (push_ok) sb_q.push_back(d);
        if (push && !push_ok) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        check_status(tag);
    endtask

    // Reset pulse with a push and pop driven alongside to show reset wins.
    task automatic do_reset(input string tag);
        rst       = 1'b1;
        wr_strobe = 1'b1;
        wr_data   = 8'hEE;
        rd_strobe = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        wr_strobe = 1'b0;
        rd_strobe = 1'b0;
        wr_data   = '0;
        sb_q.delete();
        ovf_m = 1'b0;
        check_status(tag);
    endtask

    initial begin
        rst          = 1'b1;
        wr_data      = '0;
        wr_strobe    = 1'b0;
        rd_strobe    = 1'b0;
        clr_overflow = 1'b0;
        ovf_m        = 1'b0;
        last_pop     = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        // 1. Single push and pop.
        step(1'b1, 8'hA5, 1'b0, 1'b0, "t1_push");
        check("t1_head", 32'(rd_data), 32'h A5);
        check("t1_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, "t1_pop");
        check("t1_empty_data", 32'(rd_data), 32'h0);

        // 2. Fill, overflow on the 17th push, drain in order.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "t2_fill");
        check("t2_full", 32'(full), 32'd1);
        step(1'b1, 8'h55, 1'b0, 1'b0, "t2_drop");
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_cnt", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t2_drain");
        check("t2_last", 32'(last_pop), 32'h0F);
        step(1'b0, 8'h00, 1'b0, 1'b1, "t2_clr");

        // 3. Pointer wrap.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "t3_push_a");
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t3_pop_a");
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "t3_push_b");
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t3_pop_b");
        check("t3_last", 32'(last_pop), 32'h29);
        check("t3_cnt", 32'(count), 32'd0);

        // 4. Push+pop while full.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "t4_fill");
        step(1'b1, 8'h77, 1'b1, 1'b0, "t4_pushpop");
        check("t4_cnt", 32'(count), 32'd16);
        check("t4_ovf", 32'(overflow), 32'd0);
        check("t4_head", 32'(rd_data), 32'h41);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t4_drain");
        check("t4_last", 32'(last_pop), 32'h77);

        // 5. Push+pop while empty, then pop on empty.
        step(1'b1, 8'h3C, 1'b1, 1'b0, "t5_pushpop");
        check("t5_cnt", 32'(count), 32'd1);
        check("t5_head", 32'(rd_data), 32'h3C);
        step(1'b0, 8'h00, 1'b1, 1'b0, "t5_pop");
        step(1'b0, 8'h00, 1'b1, 1'b0, "t5_pop_empty");
        check("t5_cnt0", 32'(count), 32'd0);

        // 6. Reset with count=7 and overflow set; then set-vs-clear priority.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "t6_fill");
        step(1'b1, 8'h99, 1'b0, 1'b0, "t6_drop");
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t6_pop");
        check("t6_pre_cnt", 32'(count), 32'd7);
        check("t6_pre_ovf", 32'(overflow), 32'd1);
        do_reset("t6_reset");
        check("t6_rst_cnt", 32'(count), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "t6_fill2");
        step(1'b1, 8'hAA, 1'b0, 1'b1, "t6_set_clr");
        check("t6_set_wins", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "t6_clr");
        check("t6_cleared", 32'(overflow), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, "t6_pop1");
        step(1'b1, 8'hBB, 1'b0, 1'b0, "t6_push_after");
        check("t6_head", 32'(rd_data), 32'h81);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
